// File: rtl/data_table_search_bounded.sv
// Bounded linked-list search over an external data table: walks a bucket chain
// until the key matches, the chain ends, or MAX_CHAIN_LEN nodes have been read.
// Optional event counters are built only when DATA_TABLE_SEARCH_STATS_EN is defined.
module data_table_search_bounded #(
  parameter int KEY_WIDTH     = 32,
  parameter int VALUE_WIDTH   = 32,
  parameter int A_WIDTH       = 8,
  parameter int MAX_CHAIN_LEN = 16,
  localparam int HW           = $clog2(MAX_CHAIN_LEN + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [KEY_WIDTH-1:0]   task_key_i,
  input  logic [A_WIDTH-1:0]     task_head_ptr_i,
  input  logic                   task_head_ptr_val_i,
  input  logic                   task_valid_i,
  output logic                   task_ready_o,
  input  logic                   rd_avail_i,
  output logic                   rd_en_o,
  output logic [A_WIDTH-1:0]     rd_addr_o,
  input  logic [KEY_WIDTH-1:0]   rd_key_i,
  input  logic [VALUE_WIDTH-1:0] rd_value_i,
  input  logic [A_WIDTH-1:0]     rd_next_ptr_i,
  input  logic                   rd_next_ptr_val_i,
  input  logic                   rd_data_val_i,
  output logic [KEY_WIDTH-1:0]   result_key_o,
  output logic [VALUE_WIDTH-1:0] result_value_o,
  output logic [1:0]             result_res_o,
  output logic [HW-1:0]          result_hops_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [31:0]            stat_found_o,
  output logic [31:0]            stat_miss_o,
  output logic [31:0]            stat_abort_o,
  output logic [2:0]             state_dbg_o
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready
  // are both 1; once raised, result_valid_o and the result fields hold until then.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FOUND = 3'd3,
    S_MISS  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam logic [HW-1:0] MAX_HOPS = HW'(MAX_CHAIN_LEN);

  state_t                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [A_WIDTH-1:0]     addr_q;
  logic [HW-1:0]          hops_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (task_valid_i) state_d = task_head_ptr_val_i ? S_ISSUE : S_MISS;
      S_ISSUE: if (rd_avail_i) state_d = S_WAIT;
      S_WAIT: begin
        if (rd_data_val_i) begin
          if (rd_key_i == key_q)      state_d = S_FOUND;
          else if (!rd_next_ptr_val_i) state_d = S_MISS;
          else if (hops_q == MAX_HOPS) state_d = S_ABORT;
          else                         state_d = S_ISSUE;
        end
      end
      S_FOUND, S_MISS, S_ABORT: if (result_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // value_q is cleared on accept so MISS/ABORT results always report zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      key_q   <= '0;
      value_q <= '0;
      addr_q  <= '0;
      hops_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (task_valid_i) begin
            key_q   <= task_key_i;
            value_q <= '0;
            hops_q  <= '0;
            if (task_head_ptr_val_i) addr_q <= task_head_ptr_i;
          end
        end
        S_ISSUE: if (rd_avail_i) hops_q <= hops_q + HW'(1);
        S_WAIT: begin
          if (state_d == S_FOUND) value_q <= rd_value_i;
          if (state_d == S_ISSUE) addr_q  <= rd_next_ptr_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    result_res_o = 2'd0;
    case (state_q)
      S_MISS:  result_res_o = 2'd1;
      S_ABORT: result_res_o = 2'd2;
      default: result_res_o = 2'd0;
    endcase
  end

  assign task_ready_o   = (state_q == S_IDLE);
  assign rd_en_o        = (state_q == S_ISSUE) && rd_avail_i;
  assign rd_addr_o      = addr_q;
  assign result_valid_o = (state_q == S_FOUND) || (state_q == S_MISS) || (state_q == S_ABORT);
  assign result_key_o   = key_q;
  assign result_value_o = value_q;
  assign result_hops_o  = hops_q;
  assign state_dbg_o    = state_q;

`ifdef DATA_TABLE_SEARCH_STATS_EN
  logic [31:0] found_cnt_q, miss_cnt_q, abort_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      found_cnt_q <= '0;
      miss_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else if (result_valid_o && result_ready_i) begin
      if (state_q == S_FOUND) found_cnt_q <= found_cnt_q + 32'd1;
      if (state_q == S_MISS)  miss_cnt_q  <= miss_cnt_q + 32'd1;
      if (state_q == S_ABORT) abort_cnt_q <= abort_cnt_q + 32'd1;
    end
  end

  assign stat_found_o = found_cnt_q;
  assign stat_miss_o  = miss_cnt_q;
  assign stat_abort_o = abort_cnt_q;
`else
  assign stat_found_o = '0;
  assign stat_miss_o  = '0;
  assign stat_abort_o = '0;
`endif

endmodule

// File: tb/tb_data_table_search_bounded.sv
// Scoreboard bench for data_table_search_bounded: a list-walking reference model
// predicts each result and read address; monitors compare as the DUT presents them.
module tb_data_table_search_bounded;

  localparam int KW  = 16;
  localparam int VW  = 16;
  localparam int AW  = 4;
  localparam int MC  = 4;
  localparam int HWT = $clog2(MC + 1);
  localparam int W   = KW + VW + 2 + HWT;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [KW-1:0] task_key_i = '0;
  logic [AW-1:0] task_head_ptr_i = '0;
  logic          task_head_ptr_val_i = 1'b0;
  logic          task_valid_i = 1'b0;
  logic          task_ready_o;
  logic          rd_avail_i = 1'b0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [KW-1:0] rd_key_i = '0;
  logic [VW-1:0] rd_value_i = '0;
  logic [AW-1:0] rd_next_ptr_i = '0;
  logic          rd_next_ptr_val_i = 1'b0;
  logic          rd_data_val_i = 1'b0;
  logic [KW-1:0] result_key_o;
  logic [VW-1:0] result_value_o;
  logic [1:0]    result_res_o;
  logic [HWT-1:0] result_hops_o;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
  logic [31:0]   stat_found_o, stat_miss_o, stat_abort_o;
  logic [2:0]    state_dbg_o;

  data_table_search_bounded #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .A_WIDTH(AW), .MAX_CHAIN_LEN(MC)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .task_key_i(task_key_i), .task_head_ptr_i(task_head_ptr_i),
    .task_head_ptr_val_i(task_head_ptr_val_i),
    .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
    .rd_avail_i(rd_avail_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_key_i(rd_key_i), .rd_value_i(rd_value_i), .rd_next_ptr_i(rd_next_ptr_i),
    .rd_next_ptr_val_i(rd_next_ptr_val_i), .rd_data_val_i(rd_data_val_i),
    .result_key_o(result_key_o), .result_value_o(result_value_o),
    .result_res_o(result_res_o), .result_hops_o(result_hops_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .stat_found_o(stat_found_o), .stat_miss_o(stat_miss_o), .stat_abort_o(stat_abort_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- table memory and scoreboard state ----------------
  logic [KW-1:0] m_key [16];
  logic [VW-1:0] m_val [16];
  logic [AW-1:0] m_next[16];
  logic          m_nval[16];

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int read_cnt = 0;
  int exp_found = 0, exp_miss = 0, exp_abort = 0;
  int ready_mode = 2;   // 0 random, 1 low, 2 high
  int avail_mode = 2;
  int fixed_lat = 1;    // 0 means random 1..3

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void fail_now(string name);
    n_checks++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endfunction

  // Reference model: walk the chain as the specification describes it.
  task automatic model(input logic [KW-1:0] key, input logic [AW-1:0] head, input logic hv);
    int hops = 0;
    logic [1:0] res = 2'd1;
    logic [VW-1:0] val = '0;
    logic [AW-1:0] a = head;
    if (hv) begin
      while (1) begin
        exp_addr_q.push_back(a);
        hops++;
        if (m_key[a] == key) begin res = 2'd0; val = m_val[a]; break; end
        if (!m_nval[a]) begin res = 2'd1; break; end
        if (hops == MC) begin res = 2'd2; break; end
        a = m_next[a];
      end
    end
    exp_q.push_back({key, val, res, HWT'(hops)});
  endtask

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: result_ready_i = 1'($urandom_range(0, 1));
      1: result_ready_i = 1'b0;
      default: result_ready_i = 1'b1;
    endcase
    case (avail_mode)
      0: rd_avail_i = 1'($urandom_range(0, 1));
      1: rd_avail_i = 1'b0;
      default: rd_avail_i = 1'b1;
    endcase
  end

  task automatic send_task(input logic [KW-1:0] key, input logic [AW-1:0] head,
                           input logic hv, input bit do_model);
    bit ok = 0;
    if (do_model) model(key, head, hv);
    @(posedge clk); #1;
    task_key_i = key; task_head_ptr_i = head; task_head_ptr_val_i = hv; task_valid_i = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (task_ready_o) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    task_valid_i = 1'b0;
    check("task_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_addr_q.size() == 0) break;
    end
    check("drain_results", 64'(exp_q.size()), 64'd0);
    check("drain_reads", 64'(exp_addr_q.size()), 64'd0);
  endtask

  task automatic check_stats(string tag);
`ifdef DATA_TABLE_SEARCH_STATS_EN
    check({tag, "_found"}, 64'(stat_found_o), 64'(exp_found));
    check({tag, "_miss"},  64'(stat_miss_o),  64'(exp_miss));
    check({tag, "_abort"}, 64'(stat_abort_o), 64'(exp_abort));
`else
    check({tag, "_found"}, 64'(stat_found_o), 64'd0);
    check({tag, "_miss"},  64'(stat_miss_o),  64'd0);
    check({tag, "_abort"}, 64'(stat_abort_o), 64'd0);
`endif
  endtask

  // ---------------- table read responder ----------------
  initial forever begin
    int lat;
    logic [AW-1:0] a;
    @(negedge clk);
    if (rst_n_i && rd_en_o) begin
      read_cnt++;
      a = rd_addr_o;
      check("rd_en_while_avail", 64'(rd_avail_i), 64'd1);
      if (exp_addr_q.size() == 0) fail_now("unexpected_read");
      else check("rd_addr", 64'(a), 64'(exp_addr_q.pop_front()));
      lat = (fixed_lat == 0) ? int'($urandom_range(1, 3)) : fixed_lat;
      @(posedge clk);
      repeat (lat - 1) @(posedge clk);
      #1;
      rd_key_i = m_key[a]; rd_value_i = m_val[a];
      rd_next_ptr_i = m_next[a]; rd_next_ptr_val_i = m_nval[a];
      rd_data_val_i = 1'b1;
      @(posedge clk); #1;
      rd_data_val_i = 1'b0;
      rd_key_i = '0; rd_value_i = '0;
    end
  end

  // ---------------- result monitor ----------------
  initial begin
    logic [W-1:0] cur, prev, e;
    bit held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n_i) held = 0;
      else if (result_valid_o) begin
        cur = {result_key_o, result_value_o, result_res_o, result_hops_o};
        if (held) check("result_stable", 64'(cur), 64'(prev));
        if (result_ready_i) begin
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else begin
            e = exp_q.pop_front();
            check("result", 64'(cur), 64'(e));
            case (e[HWT+1:HWT])
              2'd0: exp_found++;
              2'd1: exp_miss++;
              default: exp_abort++;
            endcase
          end
          held = 0;
        end else begin
          held = 1;
          prev = cur;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int rc;
    bit seen;
    for (int a = 0; a < 16; a++) begin
      m_key[a] = '0; m_val[a] = '0; m_next[a] = '0; m_nval[a] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_task_ready", 64'(task_ready_o), 64'd1);
    check("rst_result_valid", 64'(result_valid_o), 64'd0);
    check("rst_rd_en", 64'(rd_en_o), 64'd0);
    check("rst_rd_addr", 64'(rd_addr_o), 64'd0);
    check("rst_result", 64'({result_key_o, result_value_o, result_res_o, result_hops_o}), 64'd0);
    check("rst_state", 64'(state_dbg_o), 64'd0);
    check_stats("rst_stats");
    @(posedge clk); #1 rst_n_i = 1'b1;

    // No head pointer: NO_ENTRY, zero hops, result the cycle after accept.
    send_task(16'h0011, 4'd0, 1'b0, 1);
    check("nohead_latency", 64'(result_valid_o), 64'd1);
    drain();

    // Chain 3 -> 5 -> 9, match at the tail, read latency 2.
    m_key[3] = 16'h000A; m_nval[3] = 1'b1; m_next[3] = 4'd5;
    m_key[5] = 16'h000B; m_nval[5] = 1'b1; m_next[5] = 4'd9;
    m_key[9] = 16'h1234; m_val[9] = 16'hCAFE; m_nval[9] = 1'b0;
    fixed_lat = 2;
    rc = read_cnt;
    send_task(16'h1234, 4'd3, 1'b1, 1);
    drain();
    check("chain3_reads", 64'(read_cnt - rc), 64'd3);

    // Looped chain 10 <-> 11 with no match stops after MC reads.
    m_key[10] = 16'h000E; m_nval[10] = 1'b1; m_next[10] = 4'd11;
    m_key[11] = 16'h000E; m_nval[11] = 1'b1; m_next[11] = 4'd10;
    fixed_lat = 1;
    rc = read_cnt;
    send_task(16'h000F, 4'd10, 1'b1, 1);
    drain();
    check("loop_reads", 64'(read_cnt - rc), 64'(MC));

    // Read port busy and result back-pressure, with a second task offered meanwhile.
    m_key[12] = 16'h0055; m_val[12] = 16'h5555; m_nval[12] = 1'b0;
    avail_mode = 1; ready_mode = 1;
    send_task(16'h0055, 4'd12, 1'b1, 1);
    task_key_i = 16'h0066; task_head_ptr_val_i = 1'b0; task_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_no_rd_en", 64'(rd_en_o), 64'd0);
      check("busy_not_ready", 64'(task_ready_o), 64'd0);
    end
    avail_mode = 2;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (result_valid_o) begin seen = 1; break; end
    end
    check("stall_result_seen", 64'(seen), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("held_valid", 64'(result_valid_o), 64'd1);
      check("held_not_ready", 64'(task_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    task_valid_i = 1'b0;
    ready_mode = 2;
    drain();

    // Reset while waiting for read data; late data must be ignored.
    m_key[6] = 16'h7777; m_nval[6] = 1'b1; m_next[6] = 4'd7;
    fixed_lat = 4;
    exp_addr_q.push_back(4'd6);
    send_task(16'h0001, 4'd6, 1'b1, 0);
    @(posedge clk); #1 rst_n_i = 1'b0;
    @(posedge clk); #1 rst_n_i = 1'b1;
    exp_found = 0; exp_miss = 0; exp_abort = 0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_no_result", 64'(result_valid_o), 64'd0);
      check("post_rst_no_read", 64'(rd_en_o), 64'd0);
    end
    check("post_rst_ready", 64'(task_ready_o), 64'd1);
    check("post_rst_state", 64'(state_dbg_o), 64'd0);
    check_stats("post_rst_stats");
    drain();

    // Two FOUND, one NO_ENTRY, one CHAIN_LIMIT for the event counters.
    m_key[0] = 16'h0010; m_val[0] = 16'h0100; m_nval[0] = 1'b0;
    m_key[1] = 16'h0030; m_nval[1] = 1'b1; m_next[1] = 4'd2;
    m_key[2] = 16'h0030; m_nval[2] = 1'b1; m_next[2] = 4'd1;
    fixed_lat = 1; ready_mode = 0;
    send_task(16'h0010, 4'd0, 1'b1, 1);
    send_task(16'h0010, 4'd0, 1'b1, 1);
    send_task(16'h0020, 4'd0, 1'b1, 1);
    send_task(16'h0031, 4'd1, 1'b1, 1);
    drain();
    @(negedge clk);
    check_stats("mix_stats");

    // Randomized searches over freshly randomized tables.
    fixed_lat = 0; avail_mode = 0; ready_mode = 0;
    for (int t = 0; t < 40; t++) begin
      drain();
      for (int a = 0; a < 16; a++) begin
        m_key[a]  = KW'($urandom_range(0, 7));
        m_val[a]  = VW'($urandom);
        m_next[a] = AW'($urandom_range(0, 15));
        m_nval[a] = ($urandom_range(0, 3) != 0);
      end
      send_task(KW'($urandom_range(0, 7)), AW'($urandom_range(0, 15)),
                ($urandom_range(0, 5) != 0), 1);
    end
    drain();
    @(negedge clk);
    check_stats("final_stats");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
